// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: register indices, field positions and reset values for usb_fifo_bridge.
package usb_fifo_pkg;
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_idx_e;
    localparam int DATA_VALID  = 31;
    localparam int ST_RX_EMPTY = 16;
    localparam int ST_RX_FULL  = 17;
    localparam int ST_TX_EMPTY = 18;
    localparam int ST_TX_FULL  = 19;
    localparam int ST_TX_OVF   = 20;
    localparam int ST_RX_UDF   = 21;
    localparam int CTRL_RX_IRQ_EN = 16;
    localparam int CTRL_TX_IRQ_EN = 17;
    localparam int CTRL_FLUSH_TX  = 18;
    localparam int CTRL_FLUSH_RX  = 19;
    localparam logic [7:0] RX_THRESH_RST = 8'd1;
    localparam logic [7:0] TX_THRESH_RST = 8'd0;
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock FIFO; push while full and pop while empty are ignored, flush wins.
module sync_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge: CPU-bus register front end for the USB_CDC TX/RX byte FIFOs.
module usb_fifo_bridge
    import usb_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BUS_W    = 32,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sel_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        addr_i,
    input  logic [BUS_W-1:0]  data_i,
    output logic [BUS_W-1:0]  data_o,
    output logic              rx_irq_o,
    output logic              tx_irq_o,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    input  logic [DATA_W-1:0] out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    logic [DATA_W-1:0] rx_head;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_udf, rx_irq_en, tx_irq_en;
    logic rd_en, wr_en, cpu_push, cpu_pop, ctrl_wr, stat_wr, flush_tx, flush_rx;
    logic [7:0] rx_thresh, tx_thresh, rx_cnt8, tx_cnt8;
    logic [BUS_W-1:0] data_word, status_word, ctrl_word, rd_data;
    logic unused_bits;
    reg_idx_e idx;
    assign idx         = reg_idx_e'(addr_i);
    assign rd_en       = sel_i & read_i & !write_i;
    assign wr_en       = sel_i & write_i;
    assign cpu_push    = wr_en && idx == REG_DATA;
    assign cpu_pop     = rd_en && idx == REG_DATA;
    assign ctrl_wr     = wr_en && idx == REG_CTRL;
    assign stat_wr     = wr_en && idx == REG_STATUS;
    assign flush_tx    = ctrl_wr & data_i[CTRL_FLUSH_TX];
    assign flush_rx    = ctrl_wr & data_i[CTRL_FLUSH_RX];
    assign rx_cnt8     = 8'(rx_count);
    assign tx_cnt8     = 8'(tx_count);
    assign in_valid_o  = !tx_empty;
    assign out_ready_o = !rx_full;
    assign rx_irq_o    = rx_irq_en & (rx_cnt8 >= rx_thresh) & !rx_empty;
    assign tx_irq_o    = tx_irq_en & (tx_cnt8 <= tx_thresh);
    assign unused_bits = ^data_i[BUS_W-1:22];
    sync_byte_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk_i(clk_i), .rstn_i(rstn_i), .push(cpu_push), .pop(in_ready_i), .flush(flush_tx),
        .din(data_i[DATA_W-1:0]), .head(in_data_o), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );
    sync_byte_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk_i(clk_i), .rstn_i(rstn_i), .push(out_valid_i), .pop(cpu_pop), .flush(flush_rx),
        .din(out_data_i), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );
    always_comb begin
        data_word = '0;
        data_word[DATA_W-1:0] = rx_empty ? '0 : rx_head;
        data_word[DATA_VALID] = !rx_empty;
        status_word = '0;
        status_word[7:0] = rx_cnt8;
        status_word[15:8] = tx_cnt8;
        status_word[ST_RX_EMPTY] = rx_empty;
        status_word[ST_RX_FULL] = rx_full;
        status_word[ST_TX_EMPTY] = tx_empty;
        status_word[ST_TX_FULL] = tx_full;
        status_word[ST_TX_OVF] = tx_ovf;
        status_word[ST_RX_UDF] = rx_udf;
        ctrl_word = '0;
        ctrl_word[7:0] = rx_thresh;
        ctrl_word[15:8] = tx_thresh;
        ctrl_word[CTRL_RX_IRQ_EN] = rx_irq_en;
        ctrl_word[CTRL_TX_IRQ_EN] = tx_irq_en;
        rd_data = idx == REG_DATA   ? data_word   :
                  idx == REG_STATUS ? status_word :
                  idx == REG_CTRL   ? ctrl_word   : '0;
    end
    // data_o feeds a wired-OR read bus, so it is forced to zero outside the read-response cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_o    <= '0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            rx_thresh <= RX_THRESH_RST;
            tx_thresh <= TX_THRESH_RST;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
        end else begin
            data_o <= rd_en ? rd_data : '0;
            tx_ovf <= (cpu_push & tx_full) | (tx_ovf & !(stat_wr & data_i[ST_TX_OVF]));
            rx_udf <= (cpu_pop & rx_empty) | (rx_udf & !(stat_wr & data_i[ST_RX_UDF]));
            if (ctrl_wr) begin
                rx_thresh <= data_i[7:0];
                tx_thresh <= data_i[15:8];
                rx_irq_en <= data_i[CTRL_RX_IRQ_EN];
                tx_irq_en <= data_i[CTRL_TX_IRQ_EN];
            end
        end
    end
endmodule
